// File: rtl/aes_pkg.sv
// Shared AES-128 encryption constants, types and helpers.
// Holds the FSM state enum, round count, the byte/word/state typedefs,
// the forward S-box table and the GF(2^8) doubling helper.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned KS_W       = BLOCK_W * (NUM_ROUNDS + 1);
    localparam int unsigned ROUND_W    = 4;
    localparam int unsigned NUM_BYTES  = 16;
    localparam int unsigned NUM_COLS   = 4;

    typedef logic [7:0]         aes_byte_t;
    typedef logic [31:0]        aes_word_t;
    typedef logic [BLOCK_W-1:0] aes_state_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SUB    = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_MIX    = 3'd4,
        ST_ADDKEY = 3'd5,
        ST_DONE   = 3'd6
    } aes_fsm_e;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Forward MixColumns on one 32-bit column (combinational).
// Ports: col_i - input column, byte row0 in [31:24]
//        col_o - transformed column, same byte order
module aes_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    aes_byte_t a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Circulant matrix {02 03 01 01}; 3*a is written as xtime(a) ^ a.
    assign col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core, one transform per clock.
// Ports: Clk         - rising-edge clock
//        Reset_n     - asynchronous active-low reset
//        Start       - level request; sampled in IDLE, must drop to leave DONE
//        Plaintext   - 128-bit block, sampled in LOAD
//        KeySchedule - 11 round keys, RK0 in the top 128 bits
//        Busy        - high from LOAD through ADDKEY
//        Done        - high while in DONE
//        Ciphertext  - registered result, updated only on completion
module aes_encrypt_core
    import aes_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [BLOCK_W-1:0] Plaintext,
    input  logic [KS_W-1:0]    KeySchedule,
    output logic               Busy,
    output logic               Done,
    output logic [BLOCK_W-1:0] Ciphertext
);

    aes_fsm_e             fsm_q, fsm_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    aes_state_t           state_q, state_d;
    aes_state_t           ct_q, ct_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    aes_state_t           sub_c, shift_c, mix_c, rk_c;
    logic                 last_round_c;

    assign last_round_c = (round_q == ROUND_W'(NUM_ROUNDS));

    // Round key select for the current round.
    always_comb begin
        rk_c = '0;
        for (int unsigned r = 0; r <= NUM_ROUNDS; r++) begin
            if (round_q == ROUND_W'(r)) begin
                rk_c = KeySchedule[KS_W-1-BLOCK_W*r -: BLOCK_W];
            end
        end
    end

    // SubBytes over all 16 bytes.
    always_comb begin
        sub_c = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            sub_c[BLOCK_W-1-8*i -: 8] = SBOX[state_q[BLOCK_W-1-8*i -: 8]];
        end
    end

    // ShiftRows: byte (row r, col c) takes the byte from column (c+r) mod 4.
    always_comb begin
        shift_c = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                shift_c[BLOCK_W-1-8*(r+4*c) -: 8] =
                    state_q[BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_mix
        aes_mix_column u_mix (
            .col_i (state_q[BLOCK_W-1-32*c -: 32]),
            .col_o (mix_c[BLOCK_W-1-32*c -: 32])
        );
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:   if (Start) fsm_d = ST_LOAD;
            ST_LOAD:   fsm_d = ST_SUB;
            ST_SUB:    fsm_d = ST_SHIFT;
            ST_SHIFT:  fsm_d = last_round_c ? ST_ADDKEY : ST_MIX;
            ST_MIX:    fsm_d = ST_ADDKEY;
            ST_ADDKEY: fsm_d = last_round_c ? ST_DONE : ST_SUB;
            ST_DONE:   if (!Start) fsm_d = ST_IDLE;
            default:   fsm_d = ST_IDLE;
        endcase
    end

    // Datapath write mux and output next values.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        ct_d    = ct_q;
        case (fsm_q)
            ST_LOAD: begin
                state_d = Plaintext ^ KeySchedule[KS_W-1 -: BLOCK_W];
                round_d = ROUND_W'(1);
            end
            ST_SUB:   state_d = sub_c;
            ST_SHIFT: state_d = shift_c;
            ST_MIX:   state_d = mix_c;
            ST_ADDKEY: begin
                state_d = state_q ^ rk_c;
                if (last_round_c) begin
                    ct_d = state_q ^ rk_c;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                end
            end
            default: ;
        endcase
        busy_d = (fsm_d != ST_IDLE) && (fsm_d != ST_DONE);
        done_d = (fsm_d == ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            round_q <= '0;
            state_q <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            round_q <= round_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Ciphertext = ct_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: FIPS-197 known answers,
// handshake, Start glitch, mid-operation reset and random vectors
// against a byte-array AES-128 model with its own derived S-box.
module tb_aes_encrypt_core;

    logic          Clk;
    logic          Reset_n;
    logic          Start;
    logic [127:0]  Plaintext;
    logic [1407:0] KeySchedule;
    logic          Busy;
    logic          Done;
    logic [127:0]  Ciphertext;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    aes_encrypt_core dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Plaintext   (Plaintext),
        .KeySchedule (KeySchedule),
        .Busy        (Busy),
        .Done        (Done),
        .Ciphertext  (Ciphertext)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] ks;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rcon, sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [1407:0] ks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
                for (int row = 0; row < 4; row++)
                    for (int c = 0; c < 4; c++)
                        t[row + 4*c] = s[row + 4*((c + row) % 4)];
                s = t;
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        t[4*c]   = gmul(s[4*c], 8'h02) ^ gmul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
                        t[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 8'h02) ^ gmul(s[4*c+2], 8'h03) ^ s[4*c+3];
                        t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 8'h02) ^ gmul(s[4*c+3], 8'h03);
                        t[4*c+3] = gmul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 8'h02);
                    end
                    s = t;
                end
            end
            rk = ks[1407-128*r -: 128];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation; optional Start glitch at cycle 15 and DONE hold.
    task automatic run_op(input logic [127:0] pt, input logic [127:0] key, input string tag,
                          input bit pulse, input int hold);
        logic [1407:0] ks;
        logic [127:0]  exp_ct;
        logic [127:0]  prev_ct;
        int            cyc;
        int            busy_cnt;
        bit            stable;
        bit            hold_ok;
        ks     = expand_key(key);
        exp_ct = ref_encrypt(pt, ks);
        @(negedge Clk);
        Plaintext   = pt;
        KeySchedule = ks;
        Start       = 1'b1;
        prev_ct     = Ciphertext;
        cyc         = 0;
        busy_cnt    = 0;
        stable      = 1'b1;
        while (cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (pulse && cyc == 15) Start = 1'b0;
            else if (pulse && cyc == 16) Start = 1'b1;
            if (Busy === 1'b1) busy_cnt++;
            if (Done === 1'b1) break;
            if (Ciphertext !== prev_ct) stable = 1'b0;
        end
        check({tag, "_done"},    128'(Done), 128'd1);
        check({tag, "_latency"}, 128'(cyc - 1), 128'd40);
        check({tag, "_busy"},    128'(busy_cnt), 128'd40);
        check({tag, "_ct"},      Ciphertext, exp_ct);
        check({tag, "_stable"},  128'(stable), 128'd1);
        if (hold > 0) begin
            hold_ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge Clk);
                if (Done !== 1'b1 || Busy !== 1'b0 || Ciphertext !== exp_ct) hold_ok = 1'b0;
            end
            check({tag, "_hold"}, 128'(hold_ok), 128'd1);
        end
        Start = 1'b0;
        @(negedge Clk);
        check({tag, "_idle"}, 128'({Busy, Done}), 128'd0);
        if (hold > 0) begin
            @(negedge Clk);
            check({tag, "_norestart"}, 128'({Busy, Done}), 128'd0);
        end
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] rkey;
        logic [127:0] rpt;
        Reset_n     = 1'b0;
        Start       = 1'b0;
        Plaintext   = '0;
        KeySchedule = '0;
        build_sbox();
        #23;
        check("reset_busy", 128'(Busy), 128'd0);
        check("reset_done", 128'(Done), 128'd0);
        check("reset_ct",   Ciphertext, 128'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        run_op(PT_B, KEY_B, "appB", 1'b0, 0);
        check("appB_kat", Ciphertext, CT_B);
        run_op(PT_C, KEY_C, "appC", 1'b0, 0);
        check("appC_kat", Ciphertext, CT_C);

        run_op(PT_B, KEY_B, "hs1", 1'b0, 10);
        run_op({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, "hs2", 1'b0, 0);

        run_op(PT_C, KEY_C, "glitch", 1'b1, 0);
        check("glitch_kat", Ciphertext, CT_C);

        // Abort at cycle 20 with an asynchronous reset between clock edges.
        @(negedge Clk);
        Plaintext   = PT_B;
        KeySchedule = expand_key(KEY_B);
        Start       = 1'b1;
        repeat (20) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort_busy", 128'(Busy), 128'd0);
        check("abort_done", 128'(Done), 128'd0);
        check("abort_ct",   Ciphertext, 128'd0);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_op(PT_B, KEY_B, "after_abort", 1'b0, 0);
        check("after_abort_kat", Ciphertext, CT_B);

        for (int n = 0; n < 1000; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            run_op(rpt, rkey, "rand", 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
Parameters: none; all constants live in the shared package.
REQ-001 The block SHALL have port Clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port Start, input, 1 bit: level request to encrypt.
REQ-004 The block SHALL have port Plaintext, input, 128 bits: block to encrypt, sampled in LOAD.
REQ-005 The block SHALL have port KeySchedule, input, 1408 bits: round key r occupies bits [1407-128r : 1280-128r], r = 0..10.
REQ-006 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-007 The block SHALL have port Done, output, 1 bit: high exactly while in DONE.
REQ-008 The block SHALL have port Ciphertext, output, 128 bits: registered result.

Function
REQ-009 State byte order SHALL be column-major: byte 0 = bits [127:120]; column c = bits [127-32c : 96-32c].
REQ-010 The FSM SHALL have states IDLE, LOAD, SUB, SHIFT, MIX, ADDKEY, DONE, with one transform per clock.
REQ-011 IDLE SHALL go to LOAD on Start=1 and stay in IDLE on Start=0.
REQ-012 LOAD SHALL set state <= Plaintext XOR RK0, round <= 1, then go to SUB.
REQ-013 SUB SHALL apply forward S-box to all 16 bytes, then go to SHIFT.
REQ-014 SHIFT SHALL rotate row i left by i bytes, then go to MIX if round < 10, else to ADDKEY.
REQ-015 MIX SHALL apply forward MixColumns to all 4 columns over GF(2^8) with polynomial 0x11B, then go to ADDKEY.
REQ-016 ADDKEY SHALL XOR state with RK[round].
REQ-017 From ADDKEY with round < 10: round <= round+1, go to SUB.
REQ-018 From ADDKEY with round = 10: Ciphertext <= result, go to DONE.
REQ-019 Latency SHALL be fixed: the edge sampling Start in IDLE is edge k; DONE is entered at edge k+40 (1 LOAD + 9x4 + 3 cycles).
REQ-020 DONE SHALL hold while Start=1 and go to IDLE on the first edge with Start=0; there is no auto-restart without a low Start.
REQ-021 Start changes while Busy SHALL be ignored; the operation always completes.
REQ-022 Plaintext and KeySchedule SHALL be sampled only in their using states; the source holds them stable while Busy.
REQ-023 Ciphertext SHALL change only on the ADDKEY(round 10)->DONE edge and on reset; it holds its value through IDLE and the next operation.
REQ-024 The round counter SHALL be 4 bits with range 1..10; values 0 and 11..15 SHALL be unreachable, and the default FSM branch SHALL go to IDLE.

Reset
REQ-025 Reset_n=0 SHALL asynchronously force FSM=IDLE, round=0, state register=0, Ciphertext=0, Busy=0, Done=0, including mid-operation.
REQ-026 After Reset_n deasserts, the first Start=1 SHALL begin a clean operation, with no residue from an aborted one.

Structure
REQ-027 Package aes_pkg SHALL hold: the FSM state enum, NUM_ROUNDS=10, the byte/word/state typedefs, and the forward S-box table.
REQ-028 The state register SHALL be one 128-bit register with a single write mux selected by FSM state.
REQ-029 One sub-module, aes_mix_column (32-bit column in, 32-bit column out, combinational), SHALL be instantiated 4 times; SubBytes, ShiftRows and AddRoundKey stay inline.

Verification
REQ-030 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, PT 3243f6a8885a308d313198a2e0370734 -> Ciphertext 3925841d02dc09fbdc118597196a0b32, Done rises exactly 40 cycles after the Start-sampling edge.
REQ-031 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a; Busy high for 40 cycles.
REQ-032 Handshake: Start held high for 10 cycles after Done -> stays in DONE; Start low -> IDLE next edge; Start high again -> second encryption matches the model.
REQ-033 Start pulsed low for 1 cycle at cycle 15 of an operation -> no abort, same ciphertext, same latency.
REQ-034 Reset_n low at cycle 20 of an operation -> outputs 0 immediately, no clock needed; new Start -> correct App. B result.
REQ-035 Back-to-back random vectors (1000) against a reference model -> all ciphertexts match; Ciphertext is stable between completions.
